// File: rtl/sram_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_if
// Purpose  : SRAM pin bundle between the BIST engine and the top-level pads.
//            The top level owns the DQ tristate; data is split into
//            out / in / output-enable.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_bist_if #(
    parameter int pADDR_WIDTH = 21,
    parameter int pDATA_WIDTH = 8
);
    logic [pADDR_WIDTH-1:0] sram_a;
    logic [pDATA_WIDTH-1:0] sram_dout;
    logic [pDATA_WIDTH-1:0] sram_din;
    logic                   sram_dq_oe;
    logic                   sram_cen;
    logic                   sram_oen;
    logic                   sram_wen;

    modport master (
        output sram_a, sram_dout, sram_dq_oe, sram_cen, sram_oen, sram_wen,
        input  sram_din
    );

    modport slave (
        input  sram_a, sram_dout, sram_dq_oe, sram_cen, sram_oen, sram_wen,
        output sram_din
    );
endinterface
`default_nettype wire

// File: rtl/sram_bist.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist
// Purpose  : Built-in self-test for the external asynchronous SRAM. Writes a
//            selectable pattern over 0..addr_last, reads it back and reports
//            pass/fail, a saturating error count and the first failing address.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bist #(
    parameter int          pADDR_WIDTH   = 21,
    parameter int          pDATA_WIDTH   = 8,
    parameter int          pWAIT_CYCLES  = 2,
    parameter int          pERRCNT_WIDTH = 16,
    parameter logic [31:0] pSEED         = 32'h1
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_start,
    input  wire logic                     i_abort,
    input  wire logic [1:0]               i_mode,
    input  wire logic [pADDR_WIDTH-1:0]   i_addr_last,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pass,
    output logic [pERRCNT_WIDTH-1:0]      o_error_count,
    output logic [pADDR_WIDTH-1:0]        o_first_fail_addr,
    sram_bist_if.master                   sram
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_PULSE  = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_WAIT   = 3'd4,
        S_R_SAMPLE = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [31:0]              C_POLY      = 32'h8020_0003;
    localparam int                       C_WAIT_W    = (pWAIT_CYCLES > 1) ? $clog2(pWAIT_CYCLES) : 1;
    localparam logic [C_WAIT_W-1:0]      C_WAIT_LAST = C_WAIT_W'(pWAIT_CYCLES - 1);
    localparam logic [pERRCNT_WIDTH-1:0] C_ERR_MAX   = '1;

    state_t                   r_state, w_state_n;
    logic [pADDR_WIDTH-1:0]   r_addr, w_addr_n, r_last, w_last_n;
    logic [31:0]              r_lfsr, w_lfsr_n;
    logic [C_WAIT_W-1:0]      r_wait, w_wait_n;
    logic [1:0]               r_mode, w_mode_n;
    logic                     w_start_run, w_abort_run, w_finish, w_sample, w_at_last;
    logic                     w_cen_n, w_oen_n, w_wen_n, w_oe_n, w_wr_state, w_rd_state;

    logic [pADDR_WIDTH-1:0]   r_sram_a;
    logic [pDATA_WIDTH-1:0]   r_dout;
    logic                     r_oe, r_cen, r_oen, r_wen;

    logic [pDATA_WIDTH-1:0]   r_din, r_cmp_exp;
    logic [pADDR_WIDTH-1:0]   r_cmp_addr;
    logic                     r_cmp_vld;

    logic                     r_busy, r_done, r_pass, r_fail_seen;
    logic [pERRCNT_WIDTH-1:0] r_err;
    logic [pADDR_WIDTH-1:0]   r_ffa;

    // Data pattern for one address; LFSR state is the per-address value.
    function automatic logic [pDATA_WIDTH-1:0] f_pattern(input logic [1:0] mode,
                                                         input logic [pADDR_WIDTH-1:0] addr,
                                                         input logic [31:0] lfsr);
        logic [31:0] v_word;
        case (mode)
            2'd0:    v_word = 32'(addr);
            2'd1:    v_word = ~32'(addr);
            2'd2:    v_word = lfsr;
            default: v_word = addr[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
        return v_word[pDATA_WIDTH-1:0];
    endfunction

    // Right-shifting Galois LFSR; the tap mask is applied when bit 0 falls out.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] lfsr);
        return {1'b0, lfsr[31:1]} ^ (lfsr[0] ? C_POLY : 32'h0);
    endfunction

    assign w_at_last = (r_addr == r_last);

    // Next-state, address/LFSR sequencing and next strobe levels.
    always_comb begin
        w_state_n   = r_state;
        w_addr_n    = r_addr;
        w_last_n    = r_last;
        w_lfsr_n    = r_lfsr;
        w_wait_n    = r_wait;
        w_mode_n    = r_mode;
        w_start_run = 1'b0;
        w_abort_run = 1'b0;
        w_finish    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_n   = S_W_SETUP;
                    w_addr_n    = '0;
                    w_lfsr_n    = pSEED;
                    w_mode_n    = i_mode;
                    w_last_n    = i_addr_last;
                    w_start_run = 1'b1;
                end
            end
            S_W_SETUP: begin
                w_state_n = S_W_PULSE;
                w_wait_n  = '0;
            end
            S_W_PULSE: begin
                if (r_wait == C_WAIT_LAST) w_state_n = S_W_HOLD;
                else                       w_wait_n  = r_wait + C_WAIT_W'(1);
            end
            S_W_HOLD: begin
                w_wait_n = '0;
                if (w_at_last) begin
                    w_addr_n  = '0;
                    w_lfsr_n  = pSEED;
                    w_state_n = S_R_WAIT;
                end else begin
                    w_addr_n  = r_addr + pADDR_WIDTH'(1);
                    w_lfsr_n  = f_lfsr_step(r_lfsr);
                    w_state_n = S_W_SETUP;
                end
            end
            S_R_WAIT: begin
                if (r_wait == C_WAIT_LAST) w_state_n = S_R_SAMPLE;
                else                       w_wait_n  = r_wait + C_WAIT_W'(1);
            end
            S_R_SAMPLE: begin
                w_sample = 1'b1;
                w_wait_n = '0;
                if (w_at_last) begin
                    w_state_n = S_DONE;
                end else begin
                    w_addr_n  = r_addr + pADDR_WIDTH'(1);
                    w_lfsr_n  = f_lfsr_step(r_lfsr);
                    w_state_n = S_R_WAIT;
                end
            end
            S_DONE: begin
                // Hold one cycle so the last registered compare lands first.
                if (!r_cmp_vld) begin
                    w_finish  = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && i_abort) begin
            w_state_n   = S_IDLE;
            w_addr_n    = r_addr;
            w_lfsr_n    = r_lfsr;
            w_wait_n    = '0;
            w_sample    = 1'b0;
            w_finish    = 1'b0;
            w_abort_run = 1'b1;
        end
        w_wr_state = (w_state_n == S_W_SETUP) || (w_state_n == S_W_PULSE) || (w_state_n == S_W_HOLD);
        w_rd_state = (w_state_n == S_R_WAIT) || (w_state_n == S_R_SAMPLE);
        w_cen_n    = !(w_wr_state || w_rd_state);
        w_oen_n    = !w_rd_state;
        w_wen_n    = (w_state_n != S_W_PULSE);
        w_oe_n     = w_wr_state;
    end

    // FSM state and sequencing registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_last  <= '0;
            r_lfsr  <= pSEED;
            r_wait  <= '0;
            r_mode  <= 2'd0;
        end else begin
            r_state <= w_state_n;
            r_addr  <= w_addr_n;
            r_last  <= w_last_n;
            r_lfsr  <= w_lfsr_n;
            r_wait  <= w_wait_n;
            r_mode  <= w_mode_n;
        end
    end

    // Registered SRAM pins, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sram_a <= '0;
            r_dout   <= '0;
            r_oe     <= 1'b0;
            r_cen    <= 1'b1;
            r_oen    <= 1'b1;
            r_wen    <= 1'b1;
        end else begin
            r_sram_a <= w_addr_n;
            r_dout   <= f_pattern(w_mode_n, w_addr_n, w_lfsr_n);
            r_oe     <= w_oe_n;
            r_cen    <= w_cen_n;
            r_oen    <= w_oen_n;
            r_wen    <= w_wen_n;
        end
    end

    // Capture read data with its expected value; compared on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_din      <= '0;
            r_cmp_exp  <= '0;
            r_cmp_addr <= '0;
            r_cmp_vld  <= 1'b0;
        end else begin
            r_cmp_vld <= w_sample;
            if (w_sample) begin
                r_din      <= sram.sram_din;
                r_cmp_exp  <= f_pattern(r_mode, r_addr, r_lfsr);
                r_cmp_addr <= r_addr;
            end
        end
    end

    // Run status, saturating error count and first failing address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_ffa       <= '0;
            r_fail_seen <= 1'b0;
        end else if (w_start_run) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_ffa       <= '0;
            r_fail_seen <= 1'b0;
        end else begin
            if (r_cmp_vld && (r_din != r_cmp_exp)) begin
                if (r_err != C_ERR_MAX) r_err <= r_err + pERRCNT_WIDTH'(1);
                if (!r_fail_seen) begin
                    r_ffa       <= r_cmp_addr;
                    r_fail_seen <= 1'b1;
                end
            end
            if (w_abort_run) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= 1'b0;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (r_err == '0);
            end
        end
    end

    assign sram.sram_a       = r_sram_a;
    assign sram.sram_dout    = r_dout;
    assign sram.sram_dq_oe   = r_oe;
    assign sram.sram_cen     = r_cen;
    assign sram.sram_oen     = r_oen;
    assign sram.sram_wen     = r_wen;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_error_count     = r_err;
    assign o_first_fail_addr = r_ffa;

endmodule
`default_nettype wire

// File: tb/tb_sram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bist
// Purpose  : Self-checking bench for sram_bist with a faultable SRAM model and
//            a pattern-level reference model of a complete test run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bist;
    localparam int          AW   = 21;
    localparam int          DW   = 8;
    localparam int          WC   = 2;
    localparam int          EW   = 4;
    localparam logic [31:0] SEED = 32'h1;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [1:0]    mode;
    logic [AW-1:0] addr_last;
    logic          busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] ffa;

    int checks   = 0;
    int failures = 0;

    // fault: 0 none, 1 DQ[3] stuck 0, 2 A[0] stuck 0, 3 DQ all stuck 1
    int         fault = 0;
    logic [7:0] mem [0:63];

    sram_bist_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) sif ();

    sram_bist #(
        .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pWAIT_CYCLES(WC),
        .pERRCNT_WIDTH(EW), .pSEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort),
        .i_mode(mode), .i_addr_last(addr_last), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_error_count(err_cnt), .o_first_fail_addr(ffa),
        .sram(sif)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] eff(input logic [AW-1:0] a, input int f);
        return (f == 2) ? {a[5:1], 1'b0} : a[5:0];
    endfunction

    function automatic logic [7:0] rdf(input logic [7:0] d, input int f);
        if (f == 1) return d & 8'hF7;
        if (f == 3) return 8'hFF;
        return d;
    endfunction

    // SRAM model: write while WEn/CEn low and DQ driven, combinational read.
    assign sif.sram_din = (!sif.sram_cen && !sif.sram_oen) ? rdf(mem[eff(sif.sram_a, fault)], fault) : '0;
    always @(posedge clk)
        if (!sif.sram_cen && !sif.sram_wen && sif.sram_dq_oe)
            mem[eff(sif.sram_a, fault)] <= sif.sram_dout;

    // Bus monitor: log each write, its pulse width and any address/data motion.
    logic [28:0] wlog[$];
    int          wwid[$];
    int          cur_w = 0;
    int          stab_bad = 0;
    logic        prev_wen = 1'b1;
    logic [28:0] held = '0, prev_bus = '0;
    always @(negedge clk) begin
        if (!sif.sram_wen) begin
            if (prev_wen) begin
                wlog.push_back({sif.sram_a, sif.sram_dout});
                if ({sif.sram_a, sif.sram_dout} != prev_bus) stab_bad++;
                held  = {sif.sram_a, sif.sram_dout};
                cur_w = 1;
            end else begin
                cur_w++;
                if ({sif.sram_a, sif.sram_dout} != held) stab_bad++;
            end
        end else if (!prev_wen) begin
            wwid.push_back(cur_w);
            if ({sif.sram_a, sif.sram_dout} != held) stab_bad++;
        end
        prev_wen = sif.sram_wen;
        prev_bus = {sif.sram_a, sif.sram_dout};
    end

    // Reference model of one whole run: expected writes, error count, first fail.
    int          m_err, m_ffa;
    logic [28:0] exp_wlog[$];
    task automatic model_run(input int md, input int last, input int f);
        logic [7:0]  mm  [0:63];
        logic [7:0]  pat [0:63];
        logic [31:0] lf, a32;
        int          errs;
        exp_wlog.delete();
        lf = SEED; errs = 0; m_ffa = 0;
        for (int a = 0; a <= last; a++) begin
            a32 = a;
            case (md)
                0:       pat[a] = a32[7:0];
                1:       pat[a] = ~a32[7:0];
                2:       pat[a] = lf[7:0];
                default: pat[a] = (a % 2 == 1) ? 8'hAA : 8'h55;
            endcase
            lf = (lf >> 1) ^ (lf[0] ? POLY : 32'h0);
            exp_wlog.push_back({a32[AW-1:0], pat[a]});
            mm[eff(a32[AW-1:0], f)] = pat[a];
        end
        for (int a = 0; a <= last; a++) begin
            a32 = a;
            if (rdf(mm[eff(a32[AW-1:0], f)], f) != pat[a]) begin
                if (errs == 0) m_ffa = a;
                errs++;
            end
        end
        m_err = (errs > 15) ? 15 : errs;
    endtask

    function automatic bit log_ok();
        if (wlog.size() != exp_wlog.size() || wwid.size() != exp_wlog.size() || stab_bad != 0) return 1'b0;
        foreach (wlog[i]) if (wlog[i] !== exp_wlog[i] || wwid[i] != WC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int exp_cyc(input int last);
        return (last + 1) * (2 * WC + 3) + 2;
    endfunction

    // Pulse start and count edges until done; optionally re-pulse start mid-run.
    task automatic do_run(input int md, input int last, input int mid_at, output int cyc);
        wlog.delete(); wwid.delete(); stab_bad = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = 2'(md); addr_last = AW'(last);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom_range(0, 3)); addr_last = AW'($urandom_range(0, 63));
        cyc = 0;
        while (!done && cyc < 3000) begin
            start = (cyc == mid_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_status: got %b expected 000", {busy, done, pass}); end
        checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
        checks++; if (ffa !== '0) begin failures++; $display("FAIL reset_ffa: got %0d expected 0", ffa); end
        checks++; if (sif.sram_a !== '0 || sif.sram_dout !== '0) begin failures++; $display("FAIL reset_bus: got a=%0h d=%0h expected 0/0", sif.sram_a, sif.sram_dout); end
        checks++; if ({sif.sram_dq_oe, sif.sram_cen, sif.sram_oen, sif.sram_wen} !== 4'b0111) begin failures++; $display("FAIL reset_strobes: got %b expected 0111", {sif.sram_dq_oe, sif.sram_cen, sif.sram_oen, sif.sram_wen}); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        fault = 0; model_run(0, 7, 0);
        do_run(0, 7, -1, cyc);
        checks++; if (cyc != 58) begin failures++; $display("FAIL basic_latency: got %0d expected 58", cyc); end
        checks++; if (pass !== 1'b1 || err_cnt !== '0) begin failures++; $display("FAIL basic_result: got pass=%b err=%0d expected 1/0", pass, err_cnt); end
        checks++; if (log_ok() !== 1'b1) begin failures++; $display("FAIL basic_writes: got %0d pulses expected 8 of width %0d", wwid.size(), WC); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stuck_dq();
        int cyc;
        fault = 1; model_run(0, 15, 1);
        do_run(0, 15, -1, cyc);
        checks++; if (pass !== 1'b0 || int'(err_cnt) != m_err || m_err != 8) begin failures++; $display("FAIL dq3_errcnt: got pass=%b err=%0d expected 0/8", pass, err_cnt); end
        checks++; if (int'(ffa) != m_ffa) begin failures++; $display("FAIL dq3_ffa: got %0d expected %0d", ffa, m_ffa); end
        fault = 0;
    endtask

    task automatic test_repeat_patterns();
        int          cyc;
        logic [28:0] first[$];
        bit          same;
        for (int md = 2; md <= 3; md++) begin
            fault = 0; model_run(md, 12, 0);
            do_run(md, 12, -1, cyc);
            first = wlog;
            checks++; if (pass !== 1'b1 || log_ok() !== 1'b1) begin failures++; $display("FAIL repeat_run1_m%0d: got pass=%b writes_ok=%b expected 1/1", md, pass, log_ok()); end
            do_run(md, 12, -1, cyc);
            same = (first.size() == wlog.size());
            foreach (first[i]) if (i < wlog.size() && first[i] !== wlog[i]) same = 1'b0;
            checks++; if (pass !== 1'b1 || same !== 1'b1) begin failures++; $display("FAIL repeat_run2_m%0d: got pass=%b same=%b expected 1/1", md, pass, same); end
        end
    endtask

    task automatic test_a0_stuck();
        int cyc;
        fault = 2; model_run(3, 15, 2);
        do_run(3, 15, -1, cyc);
        checks++; if (int'(err_cnt) != 15 / 2 + 1 || int'(err_cnt) != m_err) begin failures++; $display("FAIL a0_errcnt: got %0d expected %0d", err_cnt, 15 / 2 + 1); end
        checks++; if (int'(ffa) != m_ffa) begin failures++; $display("FAIL a0_ffa: got %0d expected %0d", ffa, m_ffa); end
        fault = 0;
    endtask

    task automatic test_abort();
        int n, cyc;
        fault = 0;
        @(posedge clk); #1; start = 1'b1; mode = 2'd0; addr_last = AW'(7);
        @(posedge clk); #1; start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_start: got %b expected 1", busy); end
        n = 0;
        while (!(sif.sram_a == AW'(3) && !sif.sram_wen) && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 200) begin failures++; $display("FAIL abort_reach_a3: got timeout expected W_PULSE at address 3"); end
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        checks++; if ({sif.sram_wen, sif.sram_cen, sif.sram_dq_oe} !== 3'b110) begin failures++; $display("FAIL abort_strobes: got %b expected 110", {sif.sram_wen, sif.sram_cen, sif.sram_dq_oe}); end
        checks++; if ({done, pass, busy} !== 3'b100) begin failures++; $display("FAIL abort_status: got %b expected 100", {done, pass, busy}); end
        do_run(0, 7, -1, cyc);
        checks++; if (pass !== 1'b1 || cyc != 58) begin failures++; $display("FAIL abort_rerun: got pass=%b cyc=%0d expected 1/58", pass, cyc); end
    endtask

    task automatic test_saturate();
        int cyc;
        fault = 3; model_run(0, 31, 3);
        do_run(0, 31, -1, cyc);
        checks++; if (err_cnt !== 4'd15 || int'(err_cnt) != m_err) begin failures++; $display("FAIL sat_errcnt: got %0d expected 15", err_cnt); end
        checks++; if (ffa !== '0 || pass !== 1'b0) begin failures++; $display("FAIL sat_ffa: got ffa=%0d pass=%b expected 0/0", ffa, pass); end
        fault = 0;
    endtask

    task automatic test_reset_midrun();
        int n;
        @(posedge clk); #1; start = 1'b1; mode = 2'd1; addr_last = AW'(7);
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (sif.sram_oen && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 200) begin failures++; $display("FAIL midreset_reach_read: got timeout expected read pass"); end
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        checks++; if ({busy, done, pass, sif.sram_dq_oe, sif.sram_cen, sif.sram_oen, sif.sram_wen} !== 7'b0000111) begin failures++; $display("FAIL midreset_ctrl: got %b expected 0000111", {busy, done, pass, sif.sram_dq_oe, sif.sram_cen, sif.sram_oen, sif.sram_wen}); end
        checks++; if (err_cnt !== '0 || ffa !== '0 || sif.sram_a !== '0 || sif.sram_dout !== '0) begin failures++; $display("FAIL midreset_data: got err=%0d ffa=%0d a=%0h d=%0h expected all 0", err_cnt, ffa, sif.sram_a, sif.sram_dout); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        fault = 0; model_run(0, 7, 0);
        do_run(0, 7, 20, cyc);
        checks++; if (cyc != 58 || pass !== 1'b1) begin failures++; $display("FAIL busy_start_len: got cyc=%0d pass=%b expected 58/1", cyc, pass); end
        checks++; if (log_ok() !== 1'b1) begin failures++; $display("FAIL busy_start_mode: got writes_ok=0 expected mode-0 write sequence"); end
    endtask

    task automatic test_random();
        int md, last, cyc;
        for (int it = 0; it < 8; it++) begin
            md = $urandom_range(0, 3); last = $urandom_range(0, 31); fault = $urandom_range(0, 3);
            model_run(md, last, fault);
            do_run(md, last, -1, cyc);
            checks++; if (cyc != exp_cyc(last)) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, cyc, exp_cyc(last)); end
            checks++; if (int'(err_cnt) != m_err || int'(ffa) != m_ffa || pass !== (m_err == 0)) begin failures++; $display("FAIL rand%0d_result m=%0d l=%0d f=%0d: got err=%0d ffa=%0d pass=%b expected %0d/%0d/%b", it, md, last, fault, err_cnt, ffa, pass, m_err, m_ffa, m_err == 0); end
            checks++; if (log_ok() !== 1'b1) begin failures++; $display("FAIL rand%0d_writes: got %0d writes expected %0d", it, wlog.size(), exp_wlog.size()); end
        end
        fault = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; addr_last = '0;
        for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        test_reset();
        test_basic();
        test_stuck_dq();
        test_repeat_patterns();
        test_a0_stuck();
        test_abort();
        test_saturate();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_bist.md
# sram_bist

Parametrised built-in self-test engine for the CW310 external asynchronous SRAM, the successor to the single-shot SRAM enable check. It sits between the register block (start/mode/limit in, status out) and the top-level SRAM pins, writes a selectable data pattern over a programmable address range, reads it back, and reports pass/fail, an error count and the first failing address. The top level owns the DQ tristate; this block presents split data-out, data-in and output-enable signals.

## Interface

- pADDR_WIDTH, 21: SRAM address width.
- pDATA_WIDTH, 8: SRAM data width, 1..32.
- pWAIT_CYCLES, 2: clock cycles WEn is held low on a write, and extra cycles before a read sample; minimum 1.
- pERRCNT_WIDTH, 16: error counter width.
- pSEED, 32'h1: LFSR seed; must be nonzero.

Ports:
- clk  in  1  block clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; starts a run from IDLE.
- abort  in  1  single-cycle pulse; ends the current run.
- mode  in  2  0 addr, 1 ~addr, 2 LFSR, 3 checkerboard; sampled on start.
- addr_last  in  pADDR_WIDTH  last address tested (range 0..addr_last); sampled on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  sticky; set at end of run or abort, cleared by start.
- pass  out  1  valid when done; 1 means zero errors and no abort.
- error_count  out  pERRCNT_WIDTH  mismatches this run, saturating.
- first_fail_addr  out  pADDR_WIDTH  address of first mismatch; 0 if none.
- sram_a  out  pADDR_WIDTH  SRAM address.
- sram_dout  out  pDATA_WIDTH  write data.
- sram_din  in  pDATA_WIDTH  read data, registered internally on sample.
- sram_dq_oe  out  1  1 means drive DQ with sram_dout.
- sram_cen, sram_oen, sram_wen  out  1  active-low SRAM strobes.

## Operation

- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, R_SAMPLE, DONE.
- IDLE: strobes high, oe 0. On start, latch mode and addr_last, load LFSR with pSEED, clear error_count, first_fail_addr and done, set addr=0, go to W_SETUP.
- Write pass:
  - W_SETUP, 1 cycle: cen=0, oe=1, address and data valid.
  - W_PULSE, pWAIT_CYCLES cycles: wen=0.
  - W_HOLD, 1 cycle: wen=1, address and data still driven.
  - If addr==addr_last: reload LFSR with pSEED, set addr=0, go to R_WAIT. Otherwise advance addr and LFSR, go to W_SETUP.
- Read pass:
  - R_WAIT, pWAIT_CYCLES cycles: cen=0, oen=0, oe=0.
  - R_SAMPLE, 1 cycle: compare sram_din with expected data.
  - On mismatch: error_count+1, saturating at all-ones. If this is the first mismatch, capture addr into first_fail_addr.
  - Last address goes to DONE; otherwise advance addr and LFSR, go to R_WAIT.
- Patterns, taken from the low pDATA_WIDTH bits:
  - 0: addr.
  - 1: ~addr.
  - 2: 32-bit Galois LFSR, polynomial 0x80200003, advanced once per address.
  - 3: 0x55…55 when addr[0]=0, 0xAA…AA when addr[0]=1.
- DONE: set done, set pass = (error_count==0), go to IDLE the next cycle. Outputs hold until next start or reset.
- abort in any non-IDLE state: strobes high and oe 0 next cycle, done=1, pass=0, return to IDLE. error_count and first_fail_addr are retained.
- start while busy is ignored. start and abort together in IDLE: start wins. abort in IDLE is ignored.
- addr_last=0 tests one location.

## Timing

- Reset values: busy 0, done 0, pass 0, error_count 0, first_fail_addr 0, sram_a 0, sram_dout 0, sram_dq_oe 0, all strobes 1. Reset mid-run gives these values on the next edge and leaves no strobe low.
- All SRAM outputs are registered and change only on clk edges.
- wen never falls in the same cycle as an address or data change. Address and data are stable 1 cycle before the wen fall and 1 cycle after its rise.
- oe is 0 for at least one cycle between the last write and the first read.
- Cycles per address: write pWAIT_CYCLES+2, read pWAIT_CYCLES+1.
- Run latency from the start edge to done high is (addr_last+1)·(2·pWAIT_CYCLES+3)+2 cycles.

## Test plan

- Defaults, mode 0, addr_last=7, ideal 8-entry SRAM model: done after 8·7+2=58 cycles, pass=1, error_count=0; 8 wen pulses, each 2 cycles wide.
- Mode 0, addr_last=15, model with DQ[3] stuck at 0: pass=0, error_count=8, first_fail_addr=8.
- Mode 2 and mode 3 run twice with the ideal model: pass=1 both times, and the write sequence is identical between runs (seed reload). With A[0] stuck at 0 in mode 3: error_count=addr_last/2+1 for an odd addr_last.
- abort during the W_PULSE of address 3: next cycle wen=1, cen=1, oe=0, done=1, pass=0, busy=0. A second start then runs to pass=1.
- pERRCNT_WIDTH=4, addr_last=31, DQ all stuck at 1 in mode 0: error_count saturates at 15 with no wrap; first_fail_addr=0.
- reset asserted mid read pass: all outputs reach their reset values next cycle. start during busy is ignored: latched mode is unchanged and run length is unchanged.
